// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: one outstanding access on a req/gnt + rvalid memory bus,
// with RV funct3 size decode, lane placement/extraction, and an access timeout.
module ysyx_24100005_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_rdata,
    output logic [1:0]            out_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 store_q, store_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [1:0]           err_q, err_d;

    logic [CNT_W-1:0]     cnt_inc;
    logic [LANE_W-1:0]    lane_q;
    logic [7:0]           size_mask;
    logic [STRB_W-1:0]    wmask_full;
    logic [DATA_W-1:0]    wdata_shift;
    logic [DATA_W-1:0]    wdata_gated;
    logic [DATA_W-1:0]    load_ext;
    logic                 wr_active;

    function automatic logic is_legal(input logic store, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (DATA_W == 64);
            3'b100, 3'b101:         ok = !store;
            3'b110:                 ok = !store && (DATA_W == 64);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] a);
        logic bad;
        case (f3[1:0])
            2'd1:    bad = a[0];
            2'd2:    bad = |a[1:0];
            2'd3:    bad = |a[2:0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Shift the field to the top, then shift back arithmetically or logically
    // so one path covers every byte/half/word size and sign choice.
    function automatic logic [DATA_W-1:0] extend_load(input logic [2:0] f3,
                                                      input logic [DATA_W-1:0] raw,
                                                      input logic [LANE_W-1:0] lane);
        logic [DATA_W-1:0] field;
        logic [DATA_W-1:0] top;
        int pad;
        field = raw >> {lane, 3'b000};
        pad   = DATA_W - (8 << f3[1:0]);
        if (pad < 0) pad = 0;
        top = field << pad;
        if (f3[2]) return top >> pad;
        else       return $unsigned($signed(top) >>> pad);
    endfunction

    assign cnt_inc  = cnt_q + 1'b1;
    assign lane_q   = addr_q[LANE_W-1:0];
    assign load_ext = extend_load(funct3_q, mem_rdata, lane_q);

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign wmask_full  = size_mask[STRB_W-1:0] << lane_q;
    assign wdata_shift = wdata_q << {lane_q, 3'b000};

    // Bytes outside the enabled lanes are driven to zero.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign wdata_gated[gi*8 +: 8] = wmask_full[gi] ? wdata_shift[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign in_ready  = (state_q == S_IDLE);
    assign mem_req   = (state_q == S_REQ);
    assign wr_active = mem_req && store_q;
    assign mem_we    = wr_active;
    assign mem_wmask = wr_active ? wmask_full : '0;
    assign mem_wdata = wr_active ? wdata_gated : '0;
    assign mem_addr  = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign out_valid = (state_q == S_RESP);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    store_d  = in_store;
                    funct3_d = in_funct3;
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    err_d    = ERR_OK;
                    if (!is_legal(in_store, in_funct3)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = S_RESP;
                    end else if (is_misaligned(in_funct3, in_addr[2:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (cnt_inc == TMO) begin
                    rdata_d = '0;
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // Data arriving on the final allowed cycle still completes the access.
                if (mem_rvalid) begin
                    rdata_d = store_q ? '0 : load_ext;
                    err_d   = ERR_OK;
                    state_d = S_RESP;
                end else if (cnt_inc == TMO) begin
                    rdata_d = '0;
                    err_d   = ERR_TIMEOUT;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory/data width; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles spent in REQ+WAIT before the access is aborted; range 1..65535.
REQ-004 SHALL have ports: clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  access request; in_ready  output  1  LSU can accept a request.
REQ-007 in_store  input  1  1=store, 0=load; in_funct3  input  3  RV funct3 size/sign code.
REQ-008 in_addr  input  ADDR_W  byte address; in_wdata  input  DATA_W  store data, right-aligned.
REQ-009 mem_req  output  1  bus request; mem_we  output  1  write enable; mem_addr  output  ADDR_W  address with the low log2(DATA_W/8) bits forced to 0.
REQ-010 mem_wdata  output  DATA_W  lane-shifted store data; mem_wmask  output  DATA_W/8  byte-enable mask.
REQ-011 mem_gnt  input  1  request accepted; mem_rvalid  input  1  read data valid, or write acknowledge; mem_rdata  input  DATA_W  read data.
REQ-012 out_valid  output  1  result valid; out_ready  input  1  consumer accepts the result.
REQ-013 out_rdata  output  DATA_W  extended load result (0 for stores and on error); out_err  output  2  result status: 0=ok, 1=misaligned, 2=timeout, 3=illegal funct3.

Function
REQ-014 SHALL implement the FSM states IDLE, REQ, WAIT and RESP; in_ready SHALL equal (state==IDLE).
REQ-015 IDLE, in_valid&&in_ready: the LSU SHALL latch in_store, in_funct3, in_addr and in_wdata; the latched values SHALL be used for the whole access.
REQ-016 IDLE transitions: on an illegal funct3 or a misaligned address -> RESP with the matching out_err, and no mem_req is issued; otherwise -> REQ.
REQ-017 funct3 decoding:
- Legal for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; when DATA_W=64, also 011 LD and 110 LWU.
- Legal for stores: 000, 001, 010; when DATA_W=64, also 011.
- All other codes are illegal.
REQ-018 Misalignment: the access is misaligned when addr[0]!=0 for a half-word, addr[1:0]!=0 for a word, or addr[2:0]!=0 for a double-word; when both checks fail, illegal funct3 takes priority.
REQ-019 REQ: mem_req=1, and mem_we, mem_addr, mem_wdata and mem_wmask SHALL stay stable until the cycle in which mem_gnt=1; REQ -> WAIT on that cycle.
REQ-020 WAIT: mem_req=0; on mem_rvalid=1, mem_rdata SHALL be captured, extracted and extended, and the FSM goes -> RESP with out_err=0.
REQ-021 Load extraction:
- lane = addr[log2(DATA_W/8)-1:0]; the selected field is mem_rdata >> (8*lane).
- LB/LH/LW SHALL sign-extend the field to DATA_W bits; LBU/LHU/LWU SHALL zero-extend it; LD passes the field through.
REQ-022 Store lane placement:
- mem_wmask = {1,3,0xF,0xFF}[size] << lane.
- mem_wdata = in_wdata << (8*lane); bytes outside the mask are don't-care and SHALL be driven as 0.
REQ-023 Stores SHALL wait for mem_rvalid as the write acknowledge; mem_rdata SHALL be ignored and out_rdata SHALL be 0.
REQ-024 Timeout counter:
- Clears on entry to REQ and increments every cycle in REQ or WAIT.
- When the count reaches TIMEOUT with no mem_rvalid: -> RESP, out_err=2, out_rdata=0, mem_req dropped.
- If mem_rvalid arrives in the same cycle the count reaches TIMEOUT, the data SHALL win (out_err=0).
REQ-025 A mem_rvalid received in IDLE, REQ or RESP SHALL be ignored; a late response after a timeout is dropped.
REQ-026 RESP: out_valid=1, and out_rdata/out_err SHALL be held stable until out_ready=1; RESP -> IDLE in that cycle.
REQ-027 Back-to-back accesses: in_ready rises the cycle after the RESP handshake. A load with a 1-cycle gnt and a 1-cycle rvalid SHALL produce out_valid 3 cycles after acceptance (IDLE -> REQ -> WAIT -> RESP).
REQ-028 Only one access SHALL be outstanding at a time.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, the timeout counter to 0, and the latched request to 0.
REQ-030 During reset the outputs SHALL be: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, out_valid=0, out_rdata=0, out_err=0, in_ready=1.
REQ-031 Reset asserted mid-access SHALL abandon the access; any subsequent mem_rvalid SHALL be ignored per REQ-025.

Verification
REQ-032 LB, addr 0x8000_0003, mem_rdata 0x80AA_BBCC -> mem_addr 0x8000_0000, out_rdata 0xFFFF_FF80, out_err 0; LBU of the same access -> 0x0000_0080.
REQ-033 SH, addr 0x8000_0002, in_wdata 0x1234_ABCD -> mem_wmask 0b1100, mem_wdata 0xABCD_0000, mem_we 1; then rvalid -> out_valid, out_rdata 0.
REQ-034 LW at addr 0x8000_0001 -> no mem_req, out_valid the next cycle with out_err 1; funct3 011 with DATA_W=32 -> out_err 3.
REQ-035 TIMEOUT=4, gnt given, rvalid withheld -> out_err 2 after 4 cycles in REQ+WAIT; an rvalid injected afterwards in IDLE -> no out_valid.
REQ-036 mem_gnt delayed 5 cycles and out_ready held low 3 cycles -> mem_* and out_* stay stable throughout; in_ready stays 0 until the RESP handshake.
REQ-037 rst pulsed low while in WAIT -> the reset output values of REQ-030 apply at once; the next LW completes normally.
